// File: rtl/cnt_down_timer.sv
// Loadable down-counter timer with prescaler, pause/resume and auto-reload.
// Emits a registered one-cycle done pulse when the count expires.
module cnt_down_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] rl;
  logic [WIDTH-1:0] rl_n;
  logic [PW-1:0]    psc;
  logic [PW-1:0]    psc_n;
  logic             done_n;
  logic             tick;

  assign tick = (psc == PMAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      rl     <= '0;
      psc    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      paused <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rl     <= rl_n;
      psc    <= psc_n;
      done   <= done_n;
      busy   <= (state_n == RUN);
      paused <= (state_n == PAUSED);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rl_n    = rl;
    psc_n   = psc;
    done_n  = 1'b0;
    if (load) begin
      cnt_n   = load_val;
      rl_n    = load_val;
      psc_n   = '0;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && cnt != '0) begin
            state_n = RUN;
            psc_n   = '0;
          end
        end
        PAUSED: begin
          if (start) state_n = RUN;
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (tick) begin
            psc_n = '0;
            if (cnt > WIDTH'(1)) begin
              cnt_n = cnt - WIDTH'(1);
            end else begin
              // Expiry: cnt is 1 here, RUN never holds zero
              done_n = 1'b1;
              if (auto_reload) begin
                cnt_n = rl;
              end else begin
                cnt_n   = '0;
                state_n = IDLE;
              end
            end
          end else begin
            psc_n = psc + PW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_down_timer.sv
// Self-checking bench for cnt_down_timer: vector table, scoreboard queue
// and hand-written prescale, max-load and async-reset sequences.
module tb_cnt_down_timer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       ar = 1'b0;

  logic [7:0] cnt1, cnt4;
  logic       busy1, busy4;
  logic       paused1, paused4;
  logic       done1, done4;

  cnt_down_timer #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk(clk), .rstn(rstn), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .auto_reload(ar),
    .cnt(cnt1), .busy(busy1), .paused(paused1), .done(done1)
  );

  cnt_down_timer #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .rstn(rstn), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .auto_reload(ar),
    .cnt(cnt4), .busy(busy4), .paused(paused4), .done(done4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       ps;
    logic       ar;
    logic [7:0] ec;
    logic       eb;
    logic       ep;
    logic       ed;
  } vec_t;

  typedef struct {
    string      nm;
    bit         s4;
    logic [7:0] ec;
    logic       eb;
    logic       ep;
    logic       ed;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  exp_t cur;
  int   pass_n = 0;
  int   total_n = 0;

  task automatic check(input string nm, input logic [7:0] c,
                       input logic b, input logic p, input logic d,
                       input logic [7:0] ec, input logic eb,
                       input logic ep, input logic ed);
    total_n++;
    if (c === ec && b === eb && p === ep && d === ed) begin
      pass_n++;
    end else begin
      $display("FAIL %s: got cnt=%0d busy=%b paused=%b done=%b, want cnt=%0d busy=%b paused=%b done=%b",
               nm, c, b, p, d, ec, eb, ep, ed);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      if (cur.s4)
        check(cur.nm, cnt4, busy4, paused4, done4,
              cur.ec, cur.eb, cur.ep, cur.ed);
      else
        check(cur.nm, cnt1, busy1, paused1, done1,
              cur.ec, cur.eb, cur.ep, cur.ed);
    end
  end

  task automatic cyc(input string nm, input logic ld,
                     input logic [7:0] lv, input logic st,
                     input logic ps, input logic a,
                     input logic [7:0] ec, input logic eb,
                     input logic ep, input logic ed,
                     input bit s4 = 1'b0);
    exp_t e;
    @(negedge clk);
    load = ld;
    load_val = lv;
    start = st;
    pause = ps;
    ar = a;
    e.nm = nm;
    e.s4 = s4;
    e.ec = ec;
    e.eb = eb;
    e.ep = ep;
    e.ed = ed;
    sb.push_back(e);
  endtask

  function automatic void add(input logic ld, input logic [7:0] lv,
                              input logic st, input logic ps,
                              input logic a, input logic [7:0] ec,
                              input logic eb, input logic ep,
                              input logic ed);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.ps = ps; v.ar = a;
    v.ec = ec; v.eb = eb; v.ep = ep; v.ed = ed;
    tv.push_back(v);
  endfunction

  initial begin
    // basic countdown from 3
    add(1, 3, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 1, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // start with cnt==0 is ignored
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // pause at 3, hold, resume
    add(1, 5, 0, 0, 0, 5, 0, 0, 0);
    add(0, 0, 1, 0, 0, 5, 1, 0, 0);
    add(0, 0, 0, 0, 0, 4, 1, 0, 0);
    add(0, 0, 0, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 3, 0, 1, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 3, 0, 1, 0);
    add(0, 0, 1, 0, 0, 3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // pause+start in RUN -> PAUSED; load+pause+start -> IDLE
    add(1, 4, 0, 0, 0, 4, 0, 0, 0);
    add(0, 0, 1, 0, 0, 4, 1, 0, 0);
    add(0, 0, 1, 1, 0, 4, 0, 1, 0);
    add(0, 0, 1, 0, 0, 4, 1, 0, 0);
    add(1, 9, 1, 1, 0, 9, 0, 0, 0);
    add(0, 0, 0, 1, 0, 9, 0, 0, 0);
    add(0, 0, 0, 0, 0, 9, 0, 0, 0);
    // auto-reload: 5 periods of 2, then stop
    add(1, 2, 0, 0, 1, 2, 0, 0, 0);
    add(0, 0, 1, 0, 1, 2, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      add(0, 0, 0, 0, 1, 2, 1, 0, 1);
      add(0, 0, 0, 0, (i < 4) ? 1'b1 : 1'b0, 1, 1, 0, 0);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);

    #3;
    check("reset", cnt1, busy1, paused1, done1, 0, 0, 0, 0);
    check("reset4", cnt4, busy4, paused4, done4, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tv.size(); i++)
      cyc($sformatf("vec%0d", i), tv[i].ld, tv[i].lv, tv[i].st,
          tv[i].ps, tv[i].ar, tv[i].ec, tv[i].eb, tv[i].ep, tv[i].ed);

    // PRESCALE=4: load 2 expires 8 cycles after start
    cyc("p4_load", 1, 2, 0, 0, 0, 2, 0, 0, 0, 1'b1);
    cyc("p4_start", 0, 0, 1, 0, 0, 2, 1, 0, 0, 1'b1);
    for (int i = 1; i <= 9; i++)
      cyc($sformatf("p4_t%0d", i), 0, 0, 0, 0, 0,
          (i < 4) ? 8'd2 : (i < 8) ? 8'd1 : 8'd0,
          i < 8, 1'b0, i == 8, 1'b1);

    // max load: 255 ticks
    cyc("max_load", 1, 255, 0, 0, 0, 255, 0, 0, 0);
    cyc("max_start", 0, 0, 1, 0, 0, 255, 1, 0, 0);
    for (int i = 1; i <= 256; i++)
      cyc($sformatf("max_t%0d", i), 0, 0, 0, 0, 0,
          (i < 255) ? 8'(255 - i) : 8'd0, i < 255, 1'b0, i == 255);

    // async reset between edges at cnt=4
    cyc("ar_load", 1, 6, 0, 0, 0, 6, 0, 0, 0);
    cyc("ar_start", 0, 0, 1, 0, 0, 6, 1, 0, 0);
    cyc("ar_t1", 0, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc("ar_t2", 0, 0, 0, 0, 0, 4, 1, 0, 0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("async_rst", cnt1, busy1, paused1, done1, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++)
      cyc($sformatf("post_rst%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      total_n++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/cnt_down_timer.md
Name: cnt_down_timer

Overview:
Loadable, programmable down-counter timer. It is the counting-down complement of the lab's free-running up-counters.
- Software or FSM logic loads a start value, starts the count, and may pause and resume it.
- The block decrements once per prescaled tick and emits a one-cycle done pulse on reaching zero.
- Optional auto-reload turns it into a periodic tick source for display scanning and LED blink logic.

Parameters:
WIDTH, 8, bit width of count and load value
PRESCALE, 1, clock cycles per decrement tick (>=1); 1 means decrement every cycle

Ports:
clk  input  1  system clock, rising-edge
rstn  input  1  asynchronous active-low reset
load  input  1  load pulse: captures load_val into cnt and reload register
load_val  input  WIDTH  value to load
start  input  1  start (from IDLE) or resume (from PAUSED) pulse
pause  input  1  pause request while running
auto_reload  input  1  level: on expiry, reload and keep running instead of stopping
cnt  output  WIDTH  current count (registered)
busy  output  1  1 while in RUN
paused  output  1  1 while in PAUSED
done  output  1  one-cycle pulse, registered, on expiry

Behaviour:
- Reset: rstn asynchronous, active-low; clock clk. On reset: state=IDLE, cnt=0, reload_reg=0, prescaler=0, busy=0, paused=0, done=0. Reset mid-count aborts immediately, with no done pulse.
- States are IDLE, RUN and PAUSED. busy=(state==RUN) and paused=(state==PAUSED), both registered with the state.
- Priority per cycle: load > pause > start > tick.
- load, any state:
  - cnt<=load_val, reload_reg<=load_val, prescaler<=0, state<=IDLE, done<=0.
  - A load during RUN aborts the count without a done pulse.
- start in IDLE:
  - If cnt!=0, state<=RUN and prescaler<=0.
  - If cnt==0, start is ignored and the block stays IDLE.
- start in PAUSED: state<=RUN; prescaler resumes from its held value.
- start in RUN is ignored.
- pause in RUN: state<=PAUSED; cnt and prescaler are frozen. pause in IDLE or PAUSED is ignored.
- pause and start in the same cycle while RUN: pause wins.
- Prescaler: in RUN it counts 0..PRESCALE-1 and wraps. tick = (prescaler==PRESCALE-1). With PRESCALE=1, tick is asserted every RUN cycle.
- Tick in RUN with cnt>1: cnt<=cnt-1.
- Tick in RUN with cnt==1: done<=1 for exactly one cycle, then:
  - auto_reload=0: cnt<=0, state<=IDLE.
  - auto_reload=1: cnt<=reload_reg, state stays RUN, prescaler wraps to 0.
- Latency:
  - start sampled at edge E: RUN is visible after E.
  - First decrement at edge E+PRESCALE.
  - Load value N expires at edge E+N*PRESCALE; done is high for the cycle following that edge.
- done is 0 in every other cycle. It is never asserted in IDLE or PAUSED except in the expiry cycle itself.
- Arithmetic: unsigned, no underflow. cnt never decrements from 0, because RUN is never entered with cnt==0 and expiry leaves via 1->0 or reload.
- Max load (all ones) counts 2^WIDTH-1 ticks.
- auto_reload is sampled only at expiry; changing it mid-count has no effect until then.

Test Plan:
- Reset and basic countdown: reset; load_val=3, load; start at edge E with PRESCALE=1 -> cnt reads 3,2,1,0 after E, E+1, E+2, E+3; done=1 only in the cycle after E+3; busy falls with it; state IDLE.
- Prescaled count: PRESCALE=4, load 2, start -> cnt 2 held 4 cycles, then 1 held 4 cycles, then 0; done asserted once, 8 cycles after start.
- Pause/resume: load 5, start; pause when cnt=3 -> cnt holds 3 for 10 cycles, paused=1, busy=0; start -> count resumes 3,2,1,0 with no skipped or repeated ticks; exactly one done.
- Auto-reload: auto_reload=1, load 2, start -> cnt sequence 2,1,2,1,2... and a done pulse every 2 cycles for 5 periods; busy stays 1. Deassert auto_reload -> next expiry ends at cnt=0 and IDLE.
- Priority and corner cases:
  - start with cnt=0 -> stays IDLE, no done.
  - load+pause+start in the same RUN cycle -> cnt=load_val, IDLE.
  - pause+start in RUN -> PAUSED.
  - load_val=255 with WIDTH=8 -> done after 255 ticks.
- Async reset mid-count: assert rstn=0 between clock edges at cnt=4 -> cnt=0, busy=0, done=0 immediately; no done after release.
